ref_sched: RTL

- Parametrised refresh scheduler for the SDRAM controller; successor to the single-flag refresh counter.
- Counts a programmable refresh interval and accumulates owed refreshes in a saturating debt counter, so the controller may postpone up to MAX_DEBT refreshes.
- Drives a request/acknowledge handshake, an urgency flag and a pre-warning flag; sits between the configuration registers and the main command FSM.

---
 rtl/ref_sched_if.sv | 29 ++
 rtl/ref_sched.sv | 125 ++++++++++++
 2 files changed

// File: rtl/ref_sched_if.sv
// Handshake and status bundle between the configuration registers / command FSM
// (master) and the refresh scheduler (slave).
interface ref_sched_if #(
  parameter int CNT_W  = 16,
  parameter int DW     = 4,
  parameter int STAT_W = 16
);
  logic              en;
  logic [CNT_W-1:0]  ref_max;
  logic              ref_ack;
  logic              clr_ovf;
  logic              ref_req;
  logic              ref_urgent;
  logic              p_ref;
  logic [DW-1:0]     debt;
  logic              ovf;
  logic [STAT_W-1:0] ref_cnt;
  logic [DW-1:0]     debt_peak;

  modport master (
    output en, ref_max, ref_ack, clr_ovf,
    input  ref_req, ref_urgent, p_ref, debt, ovf, ref_cnt, debt_peak
  );

  modport slave (
    input  en, ref_max, ref_ack, clr_ovf,
    output ref_req, ref_urgent, p_ref, debt, ovf, ref_cnt, debt_peak
  );
endinterface

// File: rtl/ref_sched.sv
// Refresh scheduler: interval counter plus saturating refresh-debt accounting.
// Optional statistics (ref_cnt, debt_peak) are built only when REF_STATS_EN is defined.
module ref_sched #(
  parameter int CNT_W      = 16,
  parameter int MAX_DEBT   = 8,
  parameter int URG_THRESH = 6,
  parameter int PRE_WARN   = 3,
  parameter int STAT_W     = 16
) (
  input logic          Clk,
  input logic          Reset,
  ref_sched_if.slave   bus
);
  localparam int DW = $clog2(MAX_DEBT + 1);
  localparam logic [DW-1:0]    DEBT_MAX = DW'(MAX_DEBT);
  localparam logic [DW-1:0]    DEBT_URG = DW'(URG_THRESH);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(PRE_WARN);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0]    DEBT_ONE = {{(DW-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] rcount_r, rcount_nx_s;
  logic             armed_r;
  logic [DW-1:0]    debt_r, debt_nx_s;
  logic             ref_req_r, ref_urgent_r, p_ref_r, ovf_r;
  logic             ovf_nx_s, p_ref_nx_s;
  logic             tick_s, ack_s, sat_s;

  // Next interval count, tick/ack qualification, debt and flag updates
  always_comb begin
    rcount_nx_s = rcount_r;
    debt_nx_s   = debt_r;
    sat_s       = 1'b0;
    tick_s      = armed_r & bus.en & (rcount_r == {CNT_W{1'b0}});
    ack_s       = bus.ref_ack & (debt_r != {DW{1'b0}});

    // First edge after reset only loads the interval; en has no say there
    if (!armed_r) begin
      rcount_nx_s = bus.ref_max;
    end else if (bus.en) begin
      if (tick_s) begin
        rcount_nx_s = bus.ref_max;
      end else begin
        rcount_nx_s = rcount_r - CNT_ONE;
      end
    end else begin
      rcount_nx_s = rcount_r;
    end

    case ({tick_s, ack_s})
      2'b10: begin
        if (debt_r == DEBT_MAX) begin
          sat_s = 1'b1;
        end else begin
          debt_nx_s = debt_r + DEBT_ONE;
        end
      end
      2'b01:   debt_nx_s = debt_r - DEBT_ONE;
      default: debt_nx_s = debt_r;
    endcase

    // A lost tick outranks a simultaneous clear
    if (sat_s) begin
      ovf_nx_s = 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_nx_s = 1'b0;
    end else begin
      ovf_nx_s = ovf_r;
    end

    p_ref_nx_s = armed_r & bus.en & (rcount_nx_s != {CNT_W{1'b0}}) & (rcount_nx_s <= CNT_PRE);
  end

  // Counter, debt and registered status flags
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rcount_r     <= {CNT_W{1'b0}};
      armed_r      <= 1'b0;
      debt_r       <= {DW{1'b0}};
      ref_req_r    <= 1'b0;
      ref_urgent_r <= 1'b0;
      p_ref_r      <= 1'b0;
      ovf_r        <= 1'b0;
    end else begin
      rcount_r     <= rcount_nx_s;
      armed_r      <= 1'b1;
      debt_r       <= debt_nx_s;
      ref_req_r    <= (debt_nx_s != {DW{1'b0}});
      ref_urgent_r <= (debt_nx_s >= DEBT_URG);
      p_ref_r      <= p_ref_nx_s;
      ovf_r        <= ovf_nx_s;
    end
  end

  assign bus.debt       = debt_r;
  assign bus.ref_req    = ref_req_r;
  assign bus.ref_urgent = ref_urgent_r;
  assign bus.p_ref      = p_ref_r;
  assign bus.ovf        = ovf_r;

`ifdef REF_STATS_EN
  logic [STAT_W-1:0] ref_cnt_r;
  logic [DW-1:0]     debt_peak_r;

  // Accepted-ack count (wrapping) and high-water mark of debt
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ref_cnt_r   <= {STAT_W{1'b0}};
      debt_peak_r <= {DW{1'b0}};
    end else begin
      if (ack_s) begin
        ref_cnt_r <= ref_cnt_r + {{(STAT_W-1){1'b0}}, 1'b1};
      end
      if (debt_nx_s > debt_peak_r) begin
        debt_peak_r <= debt_nx_s;
      end
    end
  end

  assign bus.ref_cnt   = ref_cnt_r;
  assign bus.debt_peak = debt_peak_r;
`else
  assign bus.ref_cnt   = {STAT_W{1'b0}};
  assign bus.debt_peak = {DW{1'b0}};
`endif
endmodule
